// File: rtl/fb_pkg.sv
// Shared constants and types for the frame-buffer access arbiter.
// Window geometry, loader states and read-pipe source tags.
package fb_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int ADDR_WIDTH = 14;
  localparam int COORD_W    = 11;
  localparam int WIDTH      = 110;
  localparam int HEIGHT     = 145;
  localparam int FB_PIXELS  = WIDTH * HEIGHT;

  localparam logic [DATA_WIDTH-1:0] BORDER = 8'h80;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_HOLD
  } ld_state_e;

  typedef enum logic [1:0] {
    SRC_BORDER,
    SRC_RAM,
    SRC_PASS
  } rd_src_e;

  typedef struct packed {
    logic                  v;
    rd_src_e               src;
    logic [DATA_WIDTH-1:0] pix;
  } rd_tag_t;

endpackage

// File: rtl/fb_read_pipe.sv
// Fixed-latency display read pipe: carries valid, source tag and
// live/border pixel alongside the RAM access, selects q at the end.
module fb_read_pipe
  import fb_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  rd_tag_t               tag_i,
  input  logic [DATA_WIDTH-1:0] ram_rdata_i,
  output logic [DATA_WIDTH-1:0] q_o,
  output logic                  q_valid_o
);

  rd_tag_t               s1_q;
  rd_tag_t               s2_q;
  logic [DATA_WIDTH-1:0] q_q;
  logic                  qv_q;
  logic [DATA_WIDTH-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (s2_q.v) begin
      if (s2_q.src == SRC_RAM) q_d = ram_rdata_i;
      else                     q_d = s2_q.pix;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
      q_q  <= '0;
      qv_q <= 1'b0;
    end else begin
      s1_q <= tag_i;
      s2_q <= s1_q;
      q_q  <= q_d;
      qv_q <= s2_q.v;
    end
  end

  assign q_o       = q_q;
  assign q_valid_o = qv_q;

endmodule

// File: rtl/fb_access_arbiter.sv
// Single-port frame-buffer arbiter: display reads win the port,
// the frame loader fills every slot the display leaves free.
module fb_access_arbiter
  import fb_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sw1,
  input  logic                  rd_req,
  input  logic [COORD_W-1:0]    iX,
  input  logic [COORD_W-1:0]    iY,
  input  logic [DATA_WIDTH-1:0] rd,
  output logic [DATA_WIDTH-1:0] q,
  output logic                  q_valid,
  input  logic                  frame_start,
  input  logic                  wr_req,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ack,
  output logic                  wr_frame_done,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_we,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);

  localparam int AW2 = 2 * COORD_W;

  localparam logic [COORD_W-1:0]    WIN_W   = COORD_W'(WIDTH);
  localparam logic [COORD_W-1:0]    WIN_H   = COORD_W'(HEIGHT);
  localparam logic [ADDR_WIDTH-1:0] PTR_END = ADDR_WIDTH'(FB_PIXELS - 1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

  ld_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  we_q;
  logic [DATA_WIDTH-1:0] wdata_q;

  logic                  in_win;
  logic [AW2-1:0]        rd_full;
  logic                  ack;
  logic                  done;
  rd_tag_t               tag;

  assign in_win  = rd_req & ~sw1 & (iX < WIN_W) & (iY < WIN_H);
  assign rd_full = AW2'(iX) * AW2'(HEIGHT) + AW2'(iY);

  assign ack = ~rst & wr_req & ~in_win & (state_q == ST_FILL);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    done    = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_HOLD: begin
        if (frame_start) begin
          state_d = ST_FILL;
          ptr_d   = '0;
        end
      end
      ST_FILL: begin
        if (ack) begin
          if (ptr_q == PTR_END) begin
            ptr_d   = '0;
            state_d = ST_HOLD;
            done    = 1'b1;
          end else begin
            ptr_d = ptr_q + PTR_ONE;
          end
        end
        // A restart overrides both the increment and the frame end.
        if (frame_start) begin
          ptr_d   = '0;
          state_d = ST_FILL;
          done    = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
    end else if (in_win) begin
      addr_q <= rd_full[ADDR_WIDTH-1:0];
      we_q   <= 1'b0;
    end else if (ack) begin
      addr_q  <= ptr_q;
      we_q    <= 1'b1;
      wdata_q <= wr_data;
    end else begin
      we_q <= 1'b0;
    end
  end

  always_comb begin
    tag     = '0;
    tag.v   = rd_req;
    tag.pix = sw1 ? rd : BORDER;
    unique case (1'b1)
      in_win:  tag.src = SRC_RAM;
      sw1:     tag.src = SRC_PASS;
      default: tag.src = SRC_BORDER;
    endcase
  end

  fb_read_pipe u_read_pipe (
    .clk         (clk),
    .rst         (rst),
    .tag_i       (tag),
    .ram_rdata_i (ram_rdata),
    .q_o         (q),
    .q_valid_o   (q_valid)
  );

  assign wr_ack        = ack;
  assign wr_frame_done = done & ~rst;
  assign ram_addr      = addr_q;
  assign ram_we        = we_q;
  assign ram_wdata     = wdata_q;

endmodule

// File: tb/tb_fb_access_arbiter.sv
// Directed bench for fb_access_arbiter with a behavioural
// synchronous RAM and hand-computed expectations.
module tb_fb_access_arbiter;
  import fb_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  sw1;
  logic                  rd_req;
  logic [COORD_W-1:0]    iX;
  logic [COORD_W-1:0]    iY;
  logic [DATA_WIDTH-1:0] rd;
  logic [DATA_WIDTH-1:0] q;
  logic                  q_valid;
  logic                  frame_start;
  logic                  wr_req;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_ack;
  logic                  wr_frame_done;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic                  ram_we;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic [DATA_WIDTH-1:0] ram_rdata;

  logic [DATA_WIDTH-1:0] mem [16384];

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  fb_access_arbiter dut (
    .clk           (clk),
    .rst           (rst),
    .sw1           (sw1),
    .rd_req        (rd_req),
    .iX            (iX),
    .iY            (iY),
    .rd            (rd),
    .q             (q),
    .q_valid       (q_valid),
    .frame_start   (frame_start),
    .wr_req        (wr_req),
    .wr_data       (wr_data),
    .wr_ack        (wr_ack),
    .wr_frame_done (wr_frame_done),
    .ram_addr      (ram_addr),
    .ram_we        (ram_we),
    .ram_wdata     (ram_wdata),
    .ram_rdata     (ram_rdata)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic rd_txn(input string tag, input int x, input int y,
                        input logic s, input logic [7:0] live,
                        input logic win, input int ea,
                        input logic [7:0] eq);
    rd_req = 1'b1;
    iX     = COORD_W'(x);
    iY     = COORD_W'(y);
    sw1    = s;
    rd     = live;
    tick;
    rd_req = 1'b0;
    rd     = 8'h00;
    if (win) begin
      check({tag, "_addr"}, ram_addr, ea);
      check({tag, "_we"}, ram_we, 0);
    end
    check({tag, "_v1"}, q_valid, 0);
    tick;
    tick;
    check({tag, "_q"}, q, eq);
    check({tag, "_qv"}, q_valid, 1);
    tick;
    check({tag, "_hold"}, q, eq);
    check({tag, "_qv0"}, q_valid, 0);
    sw1 = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int acks, miss, bad, done_idx, done_cnt, pidx;
    logic [7:0] pdat;
    logic pend;
    logic [7:0] exp_q [4];

    rst = 1'b1; sw1 = 1'b0; rd_req = 1'b0; iX = '0; iY = '0;
    rd = '0; frame_start = 1'b0; wr_req = 1'b0; wr_data = '0;
    tick;
    tick;
    check("rst_q", q, 0);
    check("rst_qv", q_valid, 0);
    check("rst_ack", wr_ack, 0);
    check("rst_done", wr_frame_done, 0);
    check("rst_addr", ram_addr, 0);
    check("rst_we", ram_we, 0);
    check("rst_wdata", ram_wdata, 0);
    rst = 1'b0;

    // full frame fill with no display traffic
    wr_req = 1'b1;
    frame_start = 1'b1;
    #1;
    check("idle_ack", wr_ack, 0);
    tick;
    frame_start = 1'b0;
    acks = 0; miss = 0; bad = 0; done_idx = -1; done_cnt = 0;
    pidx = 0; pdat = '0;
    for (int c = 0; c < FB_PIXELS + 50 && acks < FB_PIXELS; c++) begin
      wr_data = 8'(acks) ^ 8'h80;
      #1;
      pend = wr_ack;
      if (wr_frame_done) begin
        done_idx = acks;
        done_cnt++;
      end
      if (wr_ack) begin
        pidx = acks;
        pdat = wr_data;
        acks++;
      end else begin
        miss++;
      end
      tick;
      if (pend && (ram_addr != 14'(pidx) || ram_we !== 1'b1 ||
                   ram_wdata !== pdat))
        bad++;
    end
    check("fill_acks", acks, FB_PIXELS);
    check("fill_miss", miss, 0);
    check("fill_bad", bad, 0);
    check("fill_done_idx", done_idx, FB_PIXELS - 1);
    check("fill_done_cnt", done_cnt, 1);
    check("fill_last_addr", ram_addr, 15949);
    #1;
    check("hold_ack", wr_ack, 0);
    tick;
    check("hold_we", ram_we, 0);
    wr_req = 1'b0;

    rd_txn("rd293", 2, 3, 1'b0, 8'h00, 1'b1, 293, 8'hA5);
    rd_txn("rdlast", 109, 144, 1'b0, 8'h00, 1'b1, 15949, 8'hCD);
    rd_txn("rdy145", 0, 145, 1'b0, 8'h00, 1'b0, 0, 8'h80);
    rd_txn("pass_oow", 300, 300, 1'b1, 8'h3C, 1'b0, 0, 8'h3C);

    // restart fill for arbitration cases
    frame_start = 1'b1;
    tick;
    frame_start = 1'b0;

    rd_req = 1'b1; iX = 11'd110; iY = 11'd0; sw1 = 1'b0;
    wr_req = 1'b1; wr_data = 8'h11;
    #1;
    check("oow_ack", wr_ack, 1);
    tick;
    rd_req = 1'b0; wr_req = 1'b0;
    check("oow_waddr", ram_addr, 0);
    check("oow_we", ram_we, 1);
    check("oow_wdata", ram_wdata, 8'h11);
    tick;
    tick;
    check("oow_q", q, 8'h80);
    check("oow_qv", q_valid, 1);

    rd_req = 1'b1; iX = 11'd0; iY = 11'd0;
    wr_req = 1'b1; wr_data = 8'h22;
    #1;
    check("win_ack", wr_ack, 0);
    tick;
    rd_req = 1'b0;
    check("win_we", ram_we, 0);
    check("win_addr", ram_addr, 0);
    #1;
    check("free_ack", wr_ack, 1);
    tick;
    wr_req = 1'b0;
    check("free_addr", ram_addr, 1);
    check("free_we", ram_we, 1);
    check("free_wdata", ram_wdata, 8'h22);
    tick;
    check("win_q", q, 8'h11);
    check("win_qv", q_valid, 1);
    check("we_drop", ram_we, 0);

    sw1 = 1'b1; rd = 8'h5A; rd_req = 1'b1; iX = 11'd5; iY = 11'd5;
    wr_req = 1'b1; wr_data = 8'h33;
    #1;
    check("pass_ack", wr_ack, 1);
    tick;
    rd_req = 1'b0; wr_req = 1'b0; sw1 = 1'b0; rd = 8'h00;
    check("pass_waddr", ram_addr, 2);
    check("pass_we", ram_we, 1);
    tick;
    tick;
    check("pass_q", q, 8'h5A);
    check("pass_qv", q_valid, 1);

    // sw1 toggling on back-to-back reads
    exp_q = '{8'h11, 8'hA5, 8'h22, 8'h80};
    for (int i = 0; i < 7; i++) begin
      rd_req = (i < 4);
      sw1 = (i == 0 || i == 2);
      rd  = (i == 0) ? 8'h11 : (i == 2) ? 8'h22 : 8'h00;
      iX  = (i == 1) ? 11'd2 : (i == 3) ? 11'd200 : 11'd5;
      iY  = (i == 1) ? 11'd3 : 11'd0;
      if (i >= 3) begin
        check($sformatf("tog%0d_q", i - 3), q, exp_q[i-3]);
        check($sformatf("tog%0d_qv", i - 3), q_valid, 1);
      end
      tick;
    end
    rd_req = 1'b0; sw1 = 1'b0;

    // advance loader to wr_ptr=100, then reset with reads in flight
    wr_req = 1'b1; wr_data = 8'h44;
    for (int i = 0; i < 97; i++) tick;
    check("pre_rst_addr", ram_addr, 99);
    rd_req = 1'b1; iX = 11'd1; iY = 11'd1;
    tick;
    tick;
    rd_req = 1'b0; rst = 1'b1;
    tick;
    rst = 1'b0;
    check("arst_q", q, 0);
    check("arst_qv", q_valid, 0);
    check("arst_addr", ram_addr, 0);
    check("arst_we", ram_we, 0);
    check("arst_wdata", ram_wdata, 0);
    check("arst_ack", wr_ack, 0);
    tick;
    check("arst_qv2", q_valid, 0);
    check("arst_idle_ack", wr_ack, 0);
    frame_start = 1'b1;
    tick;
    frame_start = 1'b0;
    #1;
    check("restart_ack", wr_ack, 1);
    tick;
    wr_req = 1'b0;
    check("restart_addr", ram_addr, 0);
    check("restart_we", ram_we, 1);
    check("restart_wdata", ram_wdata, 8'h44);
    tick;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
